vjtag_reg_bank: RTL and testbench

Parametrised virtual-JTAG register bank. Sits behind the vJTAG hub: it decodes the virtual IR, runs an addressed DR shift engine, and exposes `REG_CNT` fabric-side registers of `DATA_W` bits. The engine supports write, read, and auto-increment burst access, plus a status/error register. All logic runs in the `tck` domain; any crossing into the system clock is done outside this block.

---
 rtl/vjtag_reg_bank.sv | 122 ++++++++++++
 tb/tb_vjtag_reg_bank.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vjtag_reg_bank.sv
// Virtual-JTAG register bank: IR decode, addressed DR shift engine, shadow/readback registers.
// Latency: tdo valid one tck after capture; shadow/addr/err and wr_stb_o update on the udr edge.
// Backpressure: none, the TAP paces every step and fabric reads are sampled only at capture.
module vjtag_reg_bank #(
    parameter int                 IR_W    = 3,
    parameter int                 DATA_W  = 32,
    parameter int                 REG_CNT = 8,
    parameter int                 ADDR_W  = $clog2(REG_CNT),
    parameter logic [REG_CNT-1:0] RO_MASK = '0
) (
    input  logic                        tck,
    input  logic                        rst_n,
    input  logic                        tdi,
    input  logic [IR_W-1:0]             ir_in,
    input  logic                        virtual_state_cdr,
    input  logic                        virtual_state_sdr,
    input  logic                        virtual_state_e1dr,
    input  logic                        virtual_state_pdr,
    input  logic                        virtual_state_e2dr,
    input  logic                        virtual_state_udr,
    input  logic                        virtual_state_cir,
    input  logic                        virtual_state_uir,
    output logic                        tdo,
    output logic [IR_W-1:0]             ir_out,
    output logic [REG_CNT*DATA_W-1:0]   wr_data_o,
    output logic [REG_CNT-1:0]          wr_stb_o,
    input  logic [REG_CNT*DATA_W-1:0]   rd_data_i
);

    localparam logic [2:0] OP_ADDR      = 3'd1;
    localparam logic [2:0] OP_WRITE     = 3'd2;
    localparam logic [2:0] OP_READ      = 3'd3;
    localparam logic [2:0] OP_WRITE_INC = 3'd4;
    localparam logic [2:0] OP_READ_INC  = 3'd5;
    localparam logic [2:0] OP_STATUS    = 3'd6;

    logic [2:0]        op;
    logic [DATA_W-1:0] sr;
    logic              byp;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic              err;
    logic [DATA_W-1:0] shadow [REG_CNT];
    logic [ADDR_W:0]   addr_shift;
    logic              is_bypass;

    // Pause states hold everything, so their qualifiers are deliberately unused.
    logic unused_ok;
    assign unused_ok = ^{virtual_state_e1dr, virtual_state_pdr, virtual_state_e2dr,
                         virtual_state_uir, ir_in};

    assign op         = ir_in[2:0];
    assign is_bypass  = (op == 3'd0) || (op == 3'd7);
    assign tdo        = is_bypass ? byp : sr[0];
    assign addr_shift = {tdi, sr[ADDR_W-1:0]};
    assign addr_inc   = (addr == ADDR_W'(REG_CNT - 1)) ? '0 : addr + 1'b1;

    for (genvar k = 0; k < REG_CNT; k++) begin : g_wr_data
        assign wr_data_o[k*DATA_W +: DATA_W] = shadow[k];
    end

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            byp      <= 1'b0;
            addr     <= '0;
            err      <= 1'b0;
            ir_out   <= '0;
            wr_stb_o <= '0;
            for (int k = 0; k < REG_CNT; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            wr_stb_o <= '0;
            if (virtual_state_cdr) begin
                case (op)
                    OP_ADDR:                 sr <= DATA_W'(addr);
                    OP_WRITE, OP_WRITE_INC:  sr <= shadow[addr];
                    OP_READ, OP_READ_INC:    sr <= rd_data_i[int'(addr)*DATA_W +: DATA_W];
                    OP_STATUS:               sr <= DATA_W'({addr, err});
                    default:                 byp <= 1'b0;
                endcase
            end else if (virtual_state_sdr) begin
                case (op)
                    OP_ADDR:   sr[ADDR_W-1:0] <= addr_shift[ADDR_W:1];
                    OP_WRITE, OP_READ, OP_WRITE_INC, OP_READ_INC, OP_STATUS:
                               sr <= {tdi, sr[DATA_W-1:1]};
                    default:   byp <= tdi;
                endcase
            end else if (virtual_state_udr) begin
                case (op)
                    OP_ADDR: begin
                        if (32'(sr[ADDR_W-1:0]) < REG_CNT) begin
                            addr <= sr[ADDR_W-1:0];
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_WRITE, OP_WRITE_INC: begin
                        if (!RO_MASK[addr]) begin
                            shadow[addr]   <= sr;
                            wr_stb_o[addr] <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        // Burst pointer advances even when the write was rejected.
                        if (op == OP_WRITE_INC) begin
                            addr <= addr_inc;
                        end
                    end
                    OP_READ_INC: addr <= addr_inc;
                    OP_STATUS:   err  <= 1'b0;
                    default: ;
                endcase
            end
            if (virtual_state_cir) begin
                ir_out <= IR_W'(err);
            end
        end
    end

endmodule

// File: tb/tb_vjtag_reg_bank.sv
// Bench for vjtag_reg_bank: three parameterisations driven by one shared TAP stimulus,
// each compared against a transaction-level model of captures, shifts and updates.
module tb_vjtag_reg_bank;

    logic tck = 1'b0;
    always #5 tck = ~tck;

    logic       rst_n, tdi, cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir;
    logic [2:0] op;

    logic         tdo0, tdo1, tdo2;
    logic [2:0]   iro0;
    logic [4:0]   iro1;
    logic [2:0]   iro2;
    logic [255:0] wd0, rd0;
    logic [31:0]  wd1, rd1;
    logic [95:0]  wd2, rd2;
    logic [7:0]   stb0;
    logic [3:0]   stb1;
    logic [5:0]   stb2;

    vjtag_reg_bank #(.IR_W(3), .DATA_W(32), .REG_CNT(8), .RO_MASK(8'h88)) u_d0 (
        .tck(tck), .rst_n(rst_n), .tdi(tdi), .ir_in(op),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_e1dr(e1dr),
        .virtual_state_pdr(pdr), .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
        .virtual_state_cir(cir), .virtual_state_uir(uir),
        .tdo(tdo0), .ir_out(iro0), .wr_data_o(wd0), .wr_stb_o(stb0), .rd_data_i(rd0));

    vjtag_reg_bank #(.IR_W(5), .DATA_W(8), .REG_CNT(4), .RO_MASK(4'h0)) u_d1 (
        .tck(tck), .rst_n(rst_n), .tdi(tdi), .ir_in({2'b11, op}),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_e1dr(e1dr),
        .virtual_state_pdr(pdr), .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
        .virtual_state_cir(cir), .virtual_state_uir(uir),
        .tdo(tdo1), .ir_out(iro1), .wr_data_o(wd1), .wr_stb_o(stb1), .rd_data_i(rd1));

    vjtag_reg_bank #(.IR_W(3), .DATA_W(16), .REG_CNT(6), .RO_MASK(6'h02)) u_d2 (
        .tck(tck), .rst_n(rst_n), .tdi(tdi), .ir_in(op),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_e1dr(e1dr),
        .virtual_state_pdr(pdr), .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
        .virtual_state_cir(cir), .virtual_state_uir(uir),
        .tdo(tdo2), .ir_out(iro2), .wr_data_o(wd2), .wr_stb_o(stb2), .rd_data_i(rd2));

    // Reference model state, one set per instance.
    int          dw [3] = '{32, 8, 16};
    int          rc [3] = '{8, 4, 6};
    int          aw [3] = '{3, 2, 3};
    logic [7:0]  ro [3] = '{8'h88, 8'h00, 8'h02};
    logic [31:0] m_shadow [3][8];
    logic [31:0] m_rd     [3][8];
    int          m_addr   [3];
    logic        m_err    [3];

    int checks = 0;
    int errors = 0;

    always_comb begin
        rd0 = '0;
        rd1 = '0;
        rd2 = '0;
        for (int k = 0; k < 8; k++) rd0[k*32 +: 32] = m_rd[0][k];
        for (int k = 0; k < 4; k++) rd1[k*8 +: 8]   = m_rd[1][k][7:0];
        for (int k = 0; k < 6; k++) rd2[k*16 +: 16] = m_rd[2][k][15:0];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slice_of(int d, int k);
        case (d)
            0:       return wd0[k*32 +: 32];
            1:       return {24'b0, wd1[k*8 +: 8]};
            default: return {16'b0, wd2[k*16 +: 16]};
        endcase
    endfunction

    function automatic logic [7:0] stb_of(int d);
        case (d)
            0:       return stb0;
            1:       return {4'b0, stb1};
            default: return {2'b0, stb2};
        endcase
    endfunction

    function automatic logic tdo_of(int d);
        case (d)
            0:       return tdo0;
            1:       return tdo1;
            default: return tdo2;
        endcase
    endfunction

    function automatic logic [7:0] ir_of(int d);
        case (d)
            0:       return {5'b0, iro0};
            1:       return {3'b0, iro1};
            default: return {5'b0, iro2};
        endcase
    endfunction

    task automatic tick();
        @(posedge tck);
        @(negedge tck);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_addr[d] = 0;
            m_err[d]  = 1'b0;
            for (int k = 0; k < 8; k++) m_shadow[d][k] = '0;
        end
    endtask

    task automatic randomize_rd();
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 8; k++)
                m_rd[d][k] = $urandom & ((dw[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw[d]) - 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_tdo"}, 64'(tdo_of(d)), 64'd0);
            chk({tag, "_ir"}, 64'(ir_of(d)), 64'd0);
            chk({tag, "_stb"}, 64'(stb_of(d)), 64'd0);
            for (int k = 0; k < rc[d]; k++) chk({tag, "_wdata"}, 64'(slice_of(d, k)), 64'd0);
        end
    endtask

    // One DR scan: capture, n shifts (optional pause before bit pause_at), exit, update.
    task automatic scan(input logic [2:0] o, input logic [63:0] val, input int n, input int pause_at);
        logic [63:0] out_obs [3];
        logic [63:0] out_exp [3];
        logic [31:0] sr [3];
        logic [7:0]  exp_stb [3];
        int          w [3];
        int          wa [3];
        bit          wrote [3];
        logic [31:0] a;
        op = o;
        for (int d = 0; d < 3; d++) begin
            out_obs[d] = '0;
            out_exp[d] = '0;
            w[d] = dw[d];
            case (o)
                3'd1:       begin w[d] = aw[d]; sr[d] = 32'(m_addr[d]); end
                3'd2, 3'd4: sr[d] = m_shadow[d][m_addr[d]];
                3'd3, 3'd5: sr[d] = m_rd[d][m_addr[d]];
                3'd6:       sr[d] = (32'(m_addr[d]) << 1) | 32'(m_err[d]);
                default:    begin w[d] = 1; sr[d] = '0; end
            endcase
        end
        cdr = 1'b1; tick(); cdr = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == pause_at) begin
                e1dr = 1'b1; tick(); e1dr = 1'b0;
                pdr = 1'b1; repeat (4) tick(); pdr = 1'b0;
                e2dr = 1'b1; tick(); e2dr = 1'b0;
            end
            for (int d = 0; d < 3; d++) begin
                out_obs[d][i] = tdo_of(d);
                out_exp[d][i] = sr[d][0];
                sr[d] = (sr[d] >> 1) | (32'(val[i]) << (w[d] - 1));
            end
            tdi = val[i]; sdr = 1'b1; tick(); sdr = 1'b0;
        end
        e1dr = 1'b1; tick(); e1dr = 1'b0;
        for (int d = 0; d < 3; d++) begin
            exp_stb[d] = '0;
            wa[d] = m_addr[d];
            wrote[d] = 1'b0;
            case (o)
                3'd1: begin
                    a = sr[d] & ((32'd1 << aw[d]) - 1);
                    if (int'(a) < rc[d]) m_addr[d] = int'(a);
                    else m_err[d] = 1'b1;
                end
                3'd2, 3'd4: begin
                    if (ro[d][m_addr[d]]) m_err[d] = 1'b1;
                    else begin
                        m_shadow[d][m_addr[d]] = sr[d];
                        exp_stb[d] = 8'd1 << m_addr[d];
                        wrote[d] = 1'b1;
                    end
                    if (o == 3'd4) m_addr[d] = (m_addr[d] + 1) % rc[d];
                end
                3'd5: m_addr[d] = (m_addr[d] + 1) % rc[d];
                3'd6: m_err[d] = 1'b0;
                default: ;
            endcase
        end
        udr = 1'b1; tick(); udr = 1'b0;
        for (int d = 0; d < 3; d++) begin
            if (n > 0) chk($sformatf("tdo_word d%0d op%0d", d, o), out_obs[d], out_exp[d]);
            chk($sformatf("wr_stb d%0d op%0d", d, o), 64'(stb_of(d)), 64'(exp_stb[d]));
            if (wrote[d]) chk($sformatf("wr_data d%0d k%0d", d, wa[d]),
                              64'(slice_of(d, wa[d])), 64'(m_shadow[d][wa[d]]));
        end
        tick();
        for (int d = 0; d < 3; d++) chk($sformatf("wr_stb_drop d%0d", d), 64'(stb_of(d)), 64'd0);
    endtask

    task automatic ir_capture();
        cir = 1'b1; tick(); cir = 1'b0;
        for (int d = 0; d < 3; d++) chk($sformatf("ir_out d%0d", d), 64'(ir_of(d)), 64'(m_err[d]));
    endtask

    initial begin
        rst_n = 1'b0; tdi = 1'b0; op = 3'd0;
        cdr = 0; sdr = 0; e1dr = 0; pdr = 0; e2dr = 0; udr = 0; cir = 0; uir = 0;
        model_reset();
        randomize_rd();
        @(negedge tck);
        tick(); tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Write then read back through a second WRITE capture.
        scan(3'd1, 64'd5, 3, -1);
        scan(3'd2, 64'hDEAD_BEEF, 32, -1);
        scan(3'd2, {$urandom, $urandom}, 32, -1);

        // Read burst wrapping past the top register.
        m_rd[0][6] = 32'h66; m_rd[0][7] = 32'h77; m_rd[0][0] = 32'h11;
        scan(3'd1, 64'd6, 3, -1);
        repeat (3) scan(3'd5, {$urandom, $urandom}, 32, -1);
        scan(3'd6, 64'd0, 32, -1);

        // Out-of-range address, error reporting and clearing, read-only write.
        scan(3'd1, 64'd7, 3, -1);
        ir_capture();
        scan(3'd6, 64'd0, 32, -1);
        ir_capture();
        scan(3'd1, 64'd3, 3, -1);
        scan(3'd2, {$urandom, $urandom}, 32, -1);
        ir_capture();
        scan(3'd6, 64'd0, 32, -1);

        // Write burst, then a write paused mid-shift.
        scan(3'd1, 64'd1, 3, -1);
        repeat (4) scan(3'd4, {$urandom, $urandom}, 32, -1);
        scan(3'd1, 64'd2, 3, -1);
        scan(3'd2, {$urandom, $urandom}, 32, 13);
        scan(3'd2, {$urandom, $urandom}, 32, -1);

        for (int it = 0; it < 80; it++) begin
            int n;
            int p;
            logic [2:0] o;
            o = 3'($urandom_range(0, 7));
            n = (o == 3'd1) ? $urandom_range(1, 5) : $urandom_range(1, 40);
            p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            if ($urandom_range(0, 7) == 0) randomize_rd();
            scan(o, {$urandom, $urandom}, n, p);
            if ($urandom_range(0, 5) == 0) ir_capture();
        end

        // Reset in the middle of a WRITE shift discards the transfer.
        scan(3'd1, 64'd4, 3, -1);
        scan(3'd2, 64'h1234_5678, 32, -1);
        op = 3'd2;
        cdr = 1'b1; tick(); cdr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tdi = 1'($urandom); sdr = 1'b1; tick();
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midshift_reset");
        sdr = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            for (int d = 0; d < 3; d++) chk("post_reset_stb", 64'(stb_of(d)), 64'd0);
        end
        scan(3'd6, 64'd0, 32, -1);
        scan(3'd2, {$urandom, $urandom}, 32, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
